// File: rtl/ad_pkg.sv
// Shared definitions for the ADC capture path: sample width, FSM encoding, trigger modes.
package ad_pkg;

    localparam int unsigned ADC_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } cap_state_t;

    localparam logic TRIG_AUTO = 1'b0;
    localparam logic TRIG_RISE = 1'b1;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port (1-cycle latency).
// rdata holds its value while re is low, which the readout pipeline relies on.
module sample_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ad_capture.sv
// ADC capture engine: arm, trigger (auto or rising level), capture DEPTH samples,
// then stream them out over valid/ready with full throughput.
module ad_capture
    import ad_pkg::*;
#(
    parameter int unsigned DATA_W = ADC_W,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] END_RD  = CNT_W'(DEPTH);

    cap_state_t        state, state_d;
    logic [DATA_W-1:0] s_cur, s_prev;
    logic [CNT_W-1:0]  wr_addr, wr_addr_d;
    logic [CNT_W-1:0]  rd_addr, rd_addr_d;
    logic              q_valid, q_valid_d;
    logic              m_valid_d, m_last_d, done_d, busy_d;
    logic [DATA_W-1:0] m_data_d;

    logic              ram_we_c, ram_re_c;
    logic [DATA_W-1:0] ram_rdata;
    logic              trig_hit_c, hs_c, load_c;

    // Input stage; s_prev starts at all-ones so the first sample can never look like a crossing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cur  <= '0;
            s_prev <= '1;
        end else begin
            s_cur  <= ad_data;
            s_prev <= s_cur;
        end
    end

    assign trig_hit_c = (trig_mode == TRIG_AUTO) ||
                        ((trig_mode == TRIG_RISE) && (s_prev < trig_level) && (s_cur >= trig_level));
    assign hs_c   = m_valid && m_ready;
    // ram_rdata holds the word at rd_addr-1 while q_valid; move it to the output when free
    assign load_c = q_valid && (!m_valid || m_ready);

    sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .waddr (wr_addr[ADDR_W-1:0]),
        .wdata (s_cur),
        .re    (ram_re_c),
        .raddr (rd_addr[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d   = state;
        wr_addr_d = wr_addr;
        rd_addr_d = rd_addr;
        q_valid_d = q_valid;
        m_valid_d = m_valid;
        m_last_d  = m_last;
        m_data_d  = m_data;
        done_d    = 1'b0;
        ram_we_c  = 1'b0;
        ram_re_c  = 1'b0;

        if (state != IDLE && abort) begin
            state_d   = IDLE;
            q_valid_d = 1'b0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm && !abort) begin
                        state_d   = ARMED;
                        wr_addr_d = '0;
                    end
                end
                ARMED: begin
                    if (trig_hit_c) begin
                        ram_we_c  = 1'b1;
                        wr_addr_d = CNT_W'(1);
                        state_d   = CAPTURE;
                    end
                end
                CAPTURE: begin
                    ram_we_c  = 1'b1;
                    wr_addr_d = wr_addr + CNT_W'(1);
                    if (wr_addr == LAST_WR) begin
                        state_d   = READOUT;
                        rd_addr_d = '0;
                        q_valid_d = 1'b0;
                    end
                end
                READOUT: begin
                    if (hs_c) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                    end
                    if (load_c) begin
                        m_data_d  = ram_rdata;
                        m_valid_d = 1'b1;
                        m_last_d  = (rd_addr == END_RD);
                        q_valid_d = 1'b0;
                    end
                    if ((rd_addr != END_RD) && (!q_valid || load_c)) begin
                        ram_re_c  = 1'b1;
                        rd_addr_d = rd_addr + CNT_W'(1);
                        q_valid_d = 1'b1;
                    end
                    if (hs_c && m_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_addr <= '0;
            rd_addr <= '0;
            q_valid <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            wr_addr <= wr_addr_d;
            rd_addr <= rd_addr_d;
            q_valid <= q_valid_d;
            m_valid <= m_valid_d;
            m_last  <= m_last_d;
            m_data  <= m_data_d;
            done    <= done_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_ad_capture.sv
// Scoreboard bench for ad_capture: directed ramps push expected beats, a monitor pops on handshakes.
module tb_ad_capture;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned HALF   = 20;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] ad_data;
    logic              arm;
    logic              abort;
    logic              trig_mode;
    logic [DATA_W-1:0] trig_level;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    ad_capture #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ad_data    (ad_data),
        .arm        (arm),
        .abort      (abort),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .busy       (busy),
        .done       (done),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    initial clk = 1'b0;
    always #(HALF) clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t exp_q[$];

    int checks   = 0;
    int errors   = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int step     = 0;
    int rdy_mode = 0;
    int stretch_at = -100;

    logic              prev_stall   = 1'b0;
    logic              prev_last_hs = 1'b0;
    logic [DATA_W-1:0] prev_data    = '0;
    logic              prev_last    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake, checks stall stability and done timing
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {22'd0, m_valid, m_last, m_data}, {22'd0, 1'b1, prev_last, prev_data});
            if (done || prev_last_hs)
                check("done_timing", {28'd0, done, prev_last_hs, m_valid, busy}, 32'b1100);
            if (done)
                done_cnt++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h last %0d with empty scoreboard", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {23'd0, m_last, m_data}, {23'd0, e.last, e.data});
                end
                hs_cnt++;
            end
            prev_stall   = m_valid && !m_ready;
            prev_data    = m_data;
            prev_last    = m_last;
            prev_last_hs = m_valid && m_ready && m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        ad_data = DATA_W'(int'(ad_data) + step);
        if (rdy_mode == 0)
            m_ready = 1'b1;
        else if (cyc >= stretch_at && cyc < stretch_at + 20)
            m_ready = 1'b0;
        else
            m_ready = cyc[0];
    endtask

    task automatic push_ramp(input int start, input int dir);
        beat_t b;
        for (int k = 0; k < int'(DEPTH); k++) begin
            b.data = DATA_W'(start + dir * k);
            b.last = (k == int'(DEPTH) - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check(name, done_cnt - d0, 1);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic wait_hs(input string name, input int target, input int budget);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(name, {31'd0, hs_cnt >= target}, 1);
    endtask

    initial begin
        int h0;
        int d0;
        int bad;
        rst_n      = 1'b0;
        arm        = 1'b0;
        abort      = 1'b0;
        trig_mode  = 1'b0;
        trig_level = '0;
        ad_data    = '0;
        m_ready    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {20'd0, busy, done, m_valid, m_last, m_data}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_after_reset", {30'd0, busy, m_valid}, 32'd0);

        // Auto trigger, incrementing ramp from 0x10, arm pulses while busy must be ignored
        rdy_mode = 0;
        tick();
        h0 = hs_cnt;
        ad_data = 8'h10;
        step = 1;
        push_ramp(32'h10, 1);
        pulse_arm();
        check("busy_after_arm", {31'd0, busy}, 1);
        repeat (100) tick();
        pulse_arm();
        wait_hs("auto_readout_start", h0 + 10, 3000);
        pulse_arm();
        wait_done("auto_done", 3000);
        check("auto_beats", hs_cnt - h0, DEPTH);
        check("auto_idle", {30'd0, busy, m_valid}, 0);

        // Rising-level trigger at 0x80 on a decrementing ramp: fires on the 0x00 -> 0xFF wrap
        trig_mode  = 1'b1;
        trig_level = 8'h80;
        step       = 0;
        ad_data    = 8'h05;
        repeat (3) tick();
        h0 = hs_cnt;
        step = -1;
        push_ramp(32'hFF, -1);
        pulse_arm();
        repeat (3) tick();
        check("level_waiting", {30'd0, busy, m_valid}, 32'b10);
        wait_done("level_done", 3000);
        check("level_beats", hs_cnt - h0, DEPTH);

        // Backpressure: m_ready toggles with one random 20-cycle low stretch during readout
        trig_mode = 1'b0;
        rdy_mode  = 1;
        stretch_at = cyc + int'(DEPTH) + 10 + int'($urandom_range(0, 400));
        h0 = hs_cnt;
        ad_data = 8'h37;
        step = 1;
        push_ramp(32'h37, 1);
        pulse_arm();
        wait_done("bp_done", 6000);
        check("bp_beats", hs_cnt - h0, DEPTH);

        // Abort at beat 500, then a fresh auto capture
        rdy_mode = 0;
        tick();
        h0 = hs_cnt;
        d0 = done_cnt;
        ad_data = 8'hA0;
        push_ramp(32'hA0, 1);
        pulse_arm();
        wait_hs("abort_reach_500", h0 + 500, 3000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outputs", {29'd0, busy, m_valid, m_last}, 0);
        repeat (5) tick();
        check("abort_no_done", done_cnt - d0, 0);
        exp_q.delete();
        h0 = hs_cnt;
        ad_data = 8'h42;
        push_ramp(32'h42, 1);
        pulse_arm();
        wait_done("rearm_done", 3000);
        check("rearm_beats", hs_cnt - h0, DEPTH);

        // Reset mid-capture: asynchronous return to reset values, then stays idle without arm
        tick();
        ad_data = 8'h00;
        exp_q.delete();
        pulse_arm();
        repeat (300) tick();
        check("pre_reset_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #2;
        check("async_reset_outputs", {20'd0, busy, done, m_valid, m_last, m_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        bad = 0;
        h0 = hs_cnt;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (busy !== 1'b0 || m_valid !== 1'b0)
                bad++;
        end
        check("idle_after_reset_2000", bad, 0);
        check("no_beats_after_reset", hs_cnt - h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(2 * HALF * 60000);
        errors++;
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
